// File: rtl/w_forward_router_pkg.sv
// Shared field layout for the forward write router: AW/W payload positions,
// the route-queue entry format and the slave address decode.
package w_forward_router_pkg;

    localparam int AW_W        = 48;
    localparam int AW_ID_LSB   = 40;
    localparam int AW_ID_W     = 8;
    localparam int AW_LEN_LSB  = 32;
    localparam int AW_LEN_W    = 8;
    localparam int AW_ADDR_LSB = 0;
    localparam int AW_ADDR_W   = 32;

    localparam int W_W        = 37;
    localparam int W_LAST_BIT = 36;
    localparam int W_STRB_LSB = 32;
    localparam int W_STRB_W   = 4;
    localparam int W_DATA_LSB = 0;
    localparam int W_DATA_W   = 32;

    localparam int ROUTE_W = 9;

    typedef struct packed {
        logic                sel;
        logic [AW_LEN_W-1:0] len;
    } route_entry_t;

    // Slave 0 owns the bank that matches under the mask; everything else goes to slave 1.
    function automatic logic decode_sel(input logic [AW_ADDR_W-1:0] addr,
                                        input logic [AW_ADDR_W-1:0] mask,
                                        input logic [AW_ADDR_W-1:0] bank0);
        return ((addr & mask) == bank0) ? 1'b0 : 1'b1;
    endfunction

endpackage

// File: rtl/w_forward_router_route_fifo.sv
// In-order queue of AW routing decisions; pointers carry one extra wrap bit
// so full and empty are distinguished without a separate occupancy counter.
module route_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                       (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]);
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign dout      = r_mem[r_rd_ptr[IW-1:0]];

    // Pointer update; a full queue refuses a push even when a pop happens alongside it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + {{(PW-1){1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Entry storage needs no reset: the pointers define which slots are live.
    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[IW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/w_forward_router.sv
// Forward write router: steers AW by address to one of two slaves and makes
// the W beats follow the same slave, in AW order, via a route queue.
module w_forward_router
    import w_forward_router_pkg::*;
#(
    parameter logic [31:0] ADDR_MASK   = 32'hF000_0000,
    parameter logic [31:0] ADDR_BANK0  = 32'h0000_0000,
    parameter int          ROUTE_DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [AW_W-1:0] AWDATAi,
    input  logic            AWVALIDi,
    output logic            AWREADYi,
    output logic [AW_W-1:0] AWDATAo0,
    output logic [AW_W-1:0] AWDATAo1,
    output logic            AWVALIDo0,
    output logic            AWVALIDo1,
    input  logic            AWREADYo0,
    input  logic            AWREADYo1,
    input  logic [W_W-1:0]  WDATAi,
    input  logic            WVALIDi,
    output logic            WREADYi,
    output logic [W_W-1:0]  WDATAo0,
    output logic [W_W-1:0]  WDATAo1,
    output logic            WVALIDo0,
    output logic            WVALIDo1,
    input  logic            WREADYo0,
    input  logic            WREADYo1,
    output logic            ERR
);

    logic                w_sel;
    route_entry_t        w_push_entry;
    route_entry_t        w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_last;
    logic                w_pop;
    logic                w_len_err;
    logic [AW_LEN_W-1:0] r_cnt;
    logic                r_err;

    assign w_sel            = decode_sel(AWDATAi[AW_ADDR_LSB +: AW_ADDR_W], ADDR_MASK, ADDR_BANK0);
    assign w_push_entry.sel = w_sel;
    assign w_push_entry.len = AWDATAi[AW_LEN_LSB +: AW_LEN_W];

    assign AWDATAo0 = AWDATAi;
    assign AWDATAo1 = AWDATAi;
    assign WDATAo0  = WDATAi;
    assign WDATAo1  = WDATAi;

    assign w_aw_hs = AWVALIDi & AWREADYi;
    assign w_w_hs  = WVALIDi & WREADYi;
    assign w_last  = WDATAi[W_LAST_BIT];
    assign w_pop   = w_w_hs & w_last;
    assign ERR     = r_err;

    // A wrong-length burst: LAST arrives early or late relative to the queued LEN.
    assign w_len_err = w_w_hs & ((w_last & (r_cnt != w_head.len)) |
                                 (~w_last & (r_cnt == w_head.len)));

    route_fifo #(
        .WIDTH (ROUTE_W),
        .DEPTH (ROUTE_DEPTH)
    ) u_route_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (w_aw_hs),
        .pop   (w_pop),
        .din   (w_push_entry),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // AW steering: only the decoded slave sees valid, and only while the queue has room.
    always_comb begin
        AWVALIDo0 = 1'b0;
        AWVALIDo1 = 1'b0;
        AWREADYi  = 1'b0;
        if (!w_full) begin
            if (w_sel) begin
                AWVALIDo1 = AWVALIDi;
                AWREADYi  = AWREADYo1;
            end else begin
                AWVALIDo0 = AWVALIDi;
                AWREADYi  = AWREADYo0;
            end
        end else begin
            AWREADYi = 1'b0;
        end
    end

    // W steering follows the queue head; with no recorded AW the master is stalled.
    always_comb begin
        WVALIDo0 = 1'b0;
        WVALIDo1 = 1'b0;
        WREADYi  = 1'b0;
        if (!w_empty) begin
            if (w_head.sel) begin
                WVALIDo1 = WVALIDi;
                WREADYi  = WREADYo1;
            end else begin
                WVALIDo0 = WVALIDi;
                WREADYi  = WREADYo0;
            end
        end else begin
            WREADYi = 1'b0;
        end
    end

    // Beat counter within the current burst; wraps naturally so LEN=255 is a 256-beat burst.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= 8'd0;
        end else if (w_w_hs) begin
            if (w_last) begin
                r_cnt <= 8'd0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Sticky length-violation flag; it never alters routing.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if (w_len_err) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

endmodule

// File: tb/tb_w_forward_router.sv
// Bench for w_forward_router: directed scenarios then random traffic, checked
// every cycle against a queue-based model of routes and burst lengths.
module tb_w_forward_router;
    import w_forward_router_pkg::*;

    localparam logic [31:0] MASK  = 32'hF000_0000;
    localparam logic [31:0] BANK0 = 32'h0000_0000;
    localparam int          DEPTH = 4;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [AW_W-1:0] AWDATAi = '0;
    logic            AWVALIDi = 1'b0;
    logic            AWREADYi;
    logic [AW_W-1:0] AWDATAo0, AWDATAo1;
    logic            AWVALIDo0, AWVALIDo1;
    logic            AWREADYo0 = 1'b1, AWREADYo1 = 1'b1;
    logic [W_W-1:0]  WDATAi = '0;
    logic            WVALIDi = 1'b0;
    logic            WREADYi;
    logic [W_W-1:0]  WDATAo0, WDATAo1;
    logic            WVALIDo0, WVALIDo1;
    logic            WREADYo0 = 1'b1, WREADYo1 = 1'b1;
    logic            ERR;

    int total = 0;
    int bad   = 0;

    // Model: queue of {slave, len}, beats seen in the current burst, sticky error.
    logic [8:0] rq[$];
    int         m_seen = 0;
    bit         m_err = 1'b0;
    bit         m_aw_hs, m_w_hs;

    w_forward_router #(
        .ADDR_MASK   (MASK),
        .ADDR_BANK0  (BANK0),
        .ROUTE_DEPTH (DEPTH)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .AWDATAi   (AWDATAi),
        .AWVALIDi  (AWVALIDi),
        .AWREADYi  (AWREADYi),
        .AWDATAo0  (AWDATAo0),
        .AWDATAo1  (AWDATAo1),
        .AWVALIDo0 (AWVALIDo0),
        .AWVALIDo1 (AWVALIDo1),
        .AWREADYo0 (AWREADYo0),
        .AWREADYo1 (AWREADYo1),
        .WDATAi    (WDATAi),
        .WVALIDi   (WVALIDi),
        .WREADYi   (WREADYi),
        .WDATAo0   (WDATAo0),
        .WDATAo1   (WDATAo1),
        .WVALIDo0  (WVALIDo0),
        .WVALIDo1  (WVALIDo1),
        .WREADYo0  (WREADYo0),
        .WREADYo1  (WREADYo1),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW_W-1:0] mk_aw(input logic [31:0] addr, input logic [7:0] len,
                                              input logic [7:0] id);
        logic [AW_W-1:0] v;
        v = '0;
        v[AW_ADDR_LSB +: AW_ADDR_W] = addr;
        v[AW_LEN_LSB +: AW_LEN_W]   = len;
        v[AW_ID_LSB +: AW_ID_W]     = id;
        return v;
    endfunction

    function automatic logic [W_W-1:0] mk_w(input logic last, input logic [3:0] strb,
                                            input logic [31:0] data);
        logic [W_W-1:0] v;
        v = '0;
        v[W_LAST_BIT]                = last;
        v[W_STRB_LSB +: W_STRB_W]    = strb;
        v[W_DATA_LSB +: W_DATA_W]    = data;
        return v;
    endfunction

    // One clock: check outputs at the falling edge, advance the model, return at posedge+1.
    task automatic tick();
        logic       e_sel, e_full, e_empty, hsel, e_awr, e_wr, last;
        int         hlen;
        @(negedge CLK);
        e_sel   = ((AWDATAi[31:0] & MASK) != BANK0);
        e_full  = (rq.size() == DEPTH);
        e_empty = (rq.size() == 0);
        hsel    = e_empty ? 1'b0 : rq[0][8];
        hlen    = e_empty ? 0 : int'(rq[0][7:0]);
        e_awr   = !e_full && (e_sel ? AWREADYo1 : AWREADYo0);
        e_wr    = !e_empty && (hsel ? WREADYo1 : WREADYo0);
        last    = WDATAi[W_LAST_BIT];
        chk("awready",  64'(AWREADYi),  64'(e_awr));
        chk("awvalid0", 64'(AWVALIDo0), 64'(AWVALIDi && !e_full && !e_sel));
        chk("awvalid1", 64'(AWVALIDo1), 64'(AWVALIDi && !e_full && e_sel));
        chk("wready",   64'(WREADYi),   64'(e_wr));
        chk("wvalid0",  64'(WVALIDo0),  64'(WVALIDi && !e_empty && !hsel));
        chk("wvalid1",  64'(WVALIDo1),  64'(WVALIDi && !e_empty && hsel));
        chk("err",      64'(ERR),       64'(m_err));
        chk("awdata0",  64'(AWDATAo0),  64'(AWDATAi));
        chk("awdata1",  64'(AWDATAo1),  64'(AWDATAi));
        chk("wdata0",   64'(WDATAo0),   64'(WDATAi));
        chk("wdata1",   64'(WDATAo1),   64'(WDATAi));
        m_aw_hs = AWVALIDi && e_awr;
        m_w_hs  = WVALIDi && e_wr;
        if (RST) begin
            rq.delete();
            m_seen = 0;
            m_err  = 1'b0;
        end else begin
            if (m_w_hs) begin
                // Beat number (1-based, mod 256) compared with the burst's beat count LEN+1.
                if (last) begin
                    if (((m_seen + 1) % 256) != ((hlen + 1) % 256)) m_err = 1'b1;
                    void'(rq.pop_front());
                    m_seen = 0;
                end else begin
                    if (((m_seen + 1) % 256) == ((hlen + 1) % 256)) m_err = 1'b1;
                    m_seen = (m_seen + 1) % 256;
                end
            end
            if (m_aw_hs) rq.push_back({e_sel, AWDATAi[AW_LEN_LSB +: AW_LEN_W]});
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic send_aw(input logic [31:0] addr, input logic [7:0] len);
        int n;
        AWDATAi  = mk_aw(addr, len, 8'($urandom));
        AWVALIDi = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_aw_hs && n < 64);
        if (!m_aw_hs) begin
            total++;
            bad++;
            $display("FAIL aw_timeout observed=no handshake expected=handshake within 64 cycles");
        end
        AWVALIDi = 1'b0;
    endtask

    task automatic send_w(input logic last);
        int n;
        WDATAi  = mk_w(last, 4'($urandom), $urandom);
        WVALIDi = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_w_hs && n < 64);
        if (!m_w_hs) begin
            total++;
            bad++;
            $display("FAIL w_timeout observed=no handshake expected=handshake within 64 cycles");
        end
        WVALIDi = 1'b0;
    endtask

    task automatic burst(input int beats);
        for (int i = 0; i < beats; i++) send_w(i == beats - 1);
    endtask

    initial begin
        logic [31:0] r;
        logic        good_last;

        // Initial reset cycle (DUT state before it is undefined, so no checks yet).
        @(posedge CLK);
        #1;
        tick();
        RST = 1'b0;
        WVALIDi = 1'b1;
        WDATAi  = mk_w(1'b1, 4'hF, 32'h1);
        #1;
        chk("rst_wready",   64'(WREADYi),  64'(0));
        chk("rst_wvalid0",  64'(WVALIDo0), 64'(0));
        chk("rst_wvalid1",  64'(WVALIDo1), 64'(0));
        chk("rst_err",      64'(ERR),      64'(0));
        chk("rst_awready",  64'(AWREADYi), 64'(1));
        WVALIDi = 1'b0;

        // Slave-0 burst of 4 beats.
        send_aw(32'h0000_0100, 8'd3);
        burst(4);
        chk("t1_wready_empty", 64'(WREADYi), 64'(0));
        chk("t1_err", 64'(ERR), 64'(0));

        // AW and W presented together: W must wait one cycle.
        AWDATAi  = mk_aw(32'h1000_0000, 8'd0, 8'h22);
        AWVALIDi = 1'b1;
        WDATAi   = mk_w(1'b1, 4'hA, 32'hCAFE_0001);
        WVALIDi  = 1'b1;
        tick();
        AWVALIDi = 1'b0;
        chk("t2_wvalid1_next", 64'(WVALIDo1), 64'(1));
        chk("t2_wready_next",  64'(WREADYi),  64'(1));
        tick();
        WVALIDi = 1'b0;

        // Fill the queue, block a fifth AW, then drain in order.
        send_aw(32'h0000_1000, 8'd0);
        send_aw(32'h2000_0000, 8'd1);
        send_aw(32'h0FFF_FFFC, 8'd0);
        send_aw(32'hF000_0000, 8'd1);
        AWDATAi  = mk_aw(32'h0000_2000, 8'd0, 8'h55);
        AWVALIDi = 1'b1;
        tick();
        chk("t3_full_awready", 64'(AWREADYi), 64'(0));
        send_w(1'b1);
        chk("t3_rearm_awready", 64'(AWREADYi), 64'(1));
        tick();
        AWVALIDi = 1'b0;
        burst(2);
        burst(1);
        burst(2);
        burst(1);
        chk("t3_drained", 64'(WREADYi), 64'(0));

        // Length violations: LAST too early, then LAST too late.
        send_aw(32'h0000_3000, 8'd1);
        burst(1);
        chk("t4_err_set", 64'(ERR), 64'(1));
        send_aw(32'h4000_3000, 8'd1);
        burst(3);
        chk("t4_err_hold", 64'(ERR), 64'(1));

        // Reset in the middle of a burst.
        send_aw(32'h0000_0000, 8'd3);
        send_w(1'b0);
        send_w(1'b0);
        RST     = 1'b1;
        WVALIDi = 1'b1;
        WDATAi  = mk_w(1'b0, 4'h3, 32'h1234_5678);
        tick();
        RST = 1'b0;
        #1;
        chk("t5_wready", 64'(WREADYi), 64'(0));
        chk("t5_err",    64'(ERR),     64'(0));
        tick();
        tick();
        WVALIDi = 1'b0;
        send_aw(32'h8000_0040, 8'd0);
        burst(1);

        // Slave 0 back-pressure mid-burst.
        send_aw(32'h0000_0010, 8'd3);
        send_w(1'b0);
        WREADYo0 = 1'b0;
        WVALIDi  = 1'b1;
        WDATAi   = mk_w(1'b0, 4'h5, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) tick();
        WREADYo0 = 1'b1;
        tick();
        WVALIDi = 1'b0;
        send_w(1'b0);
        send_w(1'b1);
        chk("t6_err", 64'(ERR), 64'(0));

        // Maximum-length burst, the beat count wraps through 256.
        send_aw(32'h0000_0020, 8'd255);
        burst(256);
        chk("t7_len255_err", 64'(ERR), 64'(0));

        // Random traffic with occasional wrong LAST and rare resets.
        for (int i = 0; i < 800; i++) begin
            r = $urandom;
            AWVALIDi  = r[0];
            WVALIDi   = (r[2:1] != 2'b00);
            AWREADYo0 = (r[4:3] != 2'b00);
            AWREADYo1 = (r[6:5] != 2'b00);
            WREADYo0  = (r[8:7] != 2'b00);
            WREADYo1  = (r[10:9] != 2'b00);
            RST       = (r[18:11] == 8'd0);
            AWDATAi   = mk_aw(r[19] ? {4'h0, 28'($urandom)} : $urandom, 8'(r[21:20]), 8'(r[29:22]));
            good_last = (rq.size() != 0) && (m_seen == int'(rq[0][7:0]));
            WDATAi    = mk_w((r[31:30] == 2'b11) ? ~good_last : good_last, 4'($urandom), $urandom);
            tick();
        end
        RST      = 1'b0;
        AWVALIDi = 1'b0;
        WVALIDi  = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
